alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between two requesters. Each requester presents an operation (A, B and the 3-bit function code). The block arbitrates round-robin, registers the operands, drives the shared ALU and captures its result. It returns the result to the winning requester over a valid/ready handshake. It sits between the two operation sources and the shared `alu`, and it owns the ALU's `a`/`b`/`f` inputs exclusively.

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between
// two requesters, with registered operands/result and a valid/ready response.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int unsigned FW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last_served;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [FW-1:0]     r_op_f;
    logic [WIDTH-1:0]  r_resp_data;

    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_owner_ready;

    // Round-robin grant: a tie goes to the requester not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_served;
        end else if (req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
        end else if (req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
        end
    end

    // Ready is held low while reset is asserted so no accept is advertised then.
    assign w_accept      = rst_n && (r_state == IDLE) && w_grant_vld;
    assign req0_ready    = w_accept && !w_grant_id;
    assign req1_ready    = w_accept &&  w_grant_id;
    assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_owner_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_op_f        <= '0;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_resp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_op_a        <= w_grant_id ? req1_a : req0_a;
                r_op_b        <= w_grant_id ? req1_b : req0_b;
                r_op_f        <= w_grant_id ? req1_f : req0_f;
                r_owner       <= w_grant_id;
                r_last_served <= w_grant_id;
            end
            if (r_state == EXEC) begin
                r_resp_data <= alu_out;
            end
        end
    end

    assign alu_a       = r_op_a;
    assign alu_b       = r_op_b;
    assign alu_f       = r_op_f;
    assign resp_data   = r_resp_data;
    assign resp0_valid = (r_state == RESP) && !r_owner;
    assign resp1_valid = (r_state == RESP) &&  r_owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_f, req1_f;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp_data, alu_a, alu_b, alu_out;
    logic [2:0]   alu_f;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_out(alu_out)
    );

    // Shared ALU model.
    always_comb begin
        case (alu_f)
            3'b000:  alu_out = ~alu_a;
            3'b001:  alu_out = alu_a & alu_b;
            3'b010:  alu_out = alu_a ^ alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a - 32'd1;
            3'b101:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a - alu_b;
            default: alu_out = alu_a + 32'd1;
        endcase
    end

    task automatic clear_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_f = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_f = '0;
        resp0_ready = 0; resp1_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Drives one transaction for a single requester; returns the response data.
    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] f, output logic [W-1:0] data, output bit ok);
        ok = 0; data = '0;
        @(negedge clk);
        if (id == 1'b0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_f = f; end
        else            begin req1_valid = 1; req1_a = a; req1_b = b; req1_f = f; end
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (id == 1'b0) req0_valid = 0; else req1_valid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if ((id == 1'b0 && resp0_valid) || (id == 1'b1 && resp1_valid)) begin
                    data = resp_data; ok = 1; break;
                end
                @(negedge clk);
            end
        end
        if (ok) begin
            if (id == 1'b0) resp0_ready = 1; else resp1_ready = 1;
            @(negedge clk);
            resp0_ready = 0; resp1_ready = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        req0_valid = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000)
            $display("FAIL reset_handshake: got %b expected 0000",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid});
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_f, resp_data} !== '0)
            $display("FAIL reset_data: alu_a=%h alu_b=%h alu_f=%b resp_data=%h expected all 0",
                     alu_a, alu_b, alu_f, resp_data);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_and();
        bit r1_seen = 0;
        @(negedge clk);
        req0_valid = 1; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_f = 3'b001;
        #1;
        if (resp1_valid) r1_seen = 1;
        n_checks++;
        if (req0_ready !== 1'b1) $display("FAIL and_ready_T: got %b expected 1", req0_ready);
        else n_pass++;
        @(negedge clk);
        req0_valid = 0;
        #1;
        if (resp1_valid) r1_seen = 1;
        n_checks++;
        if (alu_f !== 3'b001 || alu_a !== 32'hFFFF0000)
            $display("FAIL and_alu_T1: alu_f=%b alu_a=%h expected 001/ffff0000", alu_f, alu_a);
        else n_pass++;
        @(negedge clk);
        #1;
        if (resp1_valid) r1_seen = 1;
        n_checks++;
        if (resp0_valid !== 1'b1 || resp_data !== 32'h0F0F0000)
            $display("FAIL and_resp_T2: valid=%b data=%h expected 1/0f0f0000", resp0_valid, resp_data);
        else n_pass++;
        resp0_ready = 1;
        @(negedge clk);
        resp0_ready = 0;
        #1;
        if (resp1_valid) r1_seen = 1;
        n_checks++;
        if (resp0_valid !== 1'b0) $display("FAIL and_resp_done: valid=%b expected 0", resp0_valid);
        else n_pass++;
        n_checks++;
        if (r1_seen !== 1'b0) $display("FAIL and_resp1_quiet: resp1_valid seen=%b expected 0", r1_seen);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        bit ok;
        run_op(1'b1, 32'h00000000, 32'h0, 3'b100, d, ok);
        n_checks++;
        if (!ok || d !== 32'hFFFFFFFF) $display("FAIL wrap_dec: ok=%b got %h expected ffffffff", ok, d);
        else n_pass++;
        run_op(1'b1, 32'hFFFFFFFF, 32'h1, 3'b101, d, ok);
        n_checks++;
        if (!ok || d !== 32'h00000000) $display("FAIL wrap_add: ok=%b got %h expected 00000000", ok, d);
        else n_pass++;
        run_op(1'b1, 32'h80000000, 32'h1, 3'b110, d, ok);
        n_checks++;
        if (!ok || d !== 32'h7FFFFFFF) $display("FAIL wrap_sub: ok=%b got %h expected 7fffffff", ok, d);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int order[$];
        bit both_hi = 0;
        logic [3:0] seq;
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        req0_valid = 1; req0_a = 32'h000000F0; req0_b = 32'h0000000F; req0_f = 3'b011;
        req1_valid = 1; req1_a = 32'd5;        req1_b = 32'd3;        req1_f = 3'b110;
        resp0_ready = 1; resp1_ready = 1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL sim_ready_in_reset: got %b expected 00", {req0_ready, req1_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (req0_ready && req1_ready) both_hi = 1;
            if (resp0_valid) begin
                order.push_back(0);
                n_checks++;
                if (resp_data !== 32'h000000FF) $display("FAIL sim_data0: got %h expected 000000ff", resp_data);
                else n_pass++;
            end
            if (resp1_valid) begin
                order.push_back(1);
                n_checks++;
                if (resp_data !== 32'h00000002) $display("FAIL sim_data1: got %h expected 00000002", resp_data);
                else n_pass++;
            end
            @(negedge clk);
        end
        seq = 4'b1111;
        if (order.size() >= 4) seq = {order[0][0], order[1][0], order[2][0], order[3][0]};
        n_checks++;
        if (seq !== 4'b0101) $display("FAIL sim_order: got %b (count %0d) expected 0101", seq, order.size());
        else n_pass++;
        n_checks++;
        if (both_hi !== 1'b0) $display("FAIL sim_ready_exclusive: both ready seen=%b expected 0", both_hi);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0;
        @(negedge clk);
        req0_valid = 1; req0_a = 32'h1234; req0_b = 32'h1; req0_f = 3'b101;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) $display("FAIL bp_accept0: got %b expected 1", req0_ready);
        else n_pass++;
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'd7; req1_b = 32'd2; req1_f = 3'b010;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (resp0_valid !== 1'b1 || resp_data !== 32'h1235 || req1_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: valid=%b data=%h req1_ready=%b expected 1/00001235/0",
                         i, resp0_valid, resp_data, req1_ready);
            else n_pass++;
            @(negedge clk);
        end
        resp0_ready = 1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0) $display("FAIL bp_ready_in_resp: got %b expected 0", req1_ready);
        else n_pass++;
        @(negedge clk);
        resp0_ready = 0;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) $display("FAIL bp_accept1: got %b expected 1", req1_ready);
        else n_pass++;
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        d0 = resp_data;
        n_checks++;
        if (resp1_valid !== 1'b1 || d0 !== 32'h5)
            $display("FAIL bp_resp1: valid=%b data=%h expected 1/00000005", resp1_valid, d0);
        else n_pass++;
        resp1_ready = 1;
        @(negedge clk);
        resp1_ready = 0;
    endtask

    task automatic test_reset_mid_exec();
        bit pulse = 0;
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_a = 32'd5; req0_b = 32'd0; req0_f = 3'b111;
        @(negedge clk);
        req0_valid = 0;
        #1;
        n_checks++;
        if (alu_a !== 32'd5 || alu_f !== 3'b111)
            $display("FAIL rst_in_exec: alu_a=%h alu_f=%b expected 00000005/111", alu_a, alu_f);
        else n_pass++;
        #1 rst_n = 0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_f, resp_data} !== '0 ||
            {req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000)
            $display("FAIL rst_async: alu_a=%h alu_f=%b data=%h hs=%b expected all 0",
                     alu_a, alu_f, resp_data, {req0_ready, req1_ready, resp0_valid, resp1_valid});
        else n_pass++;
        req0_valid = 1; req0_a = 32'd9; req0_b = 32'd0; req0_f = 3'b111;
        req1_valid = 1; req1_a = 32'd1; req1_b = 32'd0; req1_f = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (resp0_valid || resp1_valid) pulse = 1;
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        if (resp0_valid || resp1_valid) pulse = 1;
        n_checks++;
        if (pulse !== 1'b0) $display("FAIL rst_no_pulse: response seen=%b expected 0", pulse);
        else n_pass++;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rst_first_tie: got %b expected 10", {req0_ready, req1_ready});
        else n_pass++;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (resp0_valid !== 1'b1 || resp_data !== 32'd10)
            $display("FAIL rst_after_op: valid=%b data=%h expected 1/0000000a", resp0_valid, resp_data);
        else n_pass++;
        resp0_ready = 1;
        @(negedge clk);
        resp0_ready = 0;
    endtask

    task automatic test_withdrawal();
        bit r0_seen = 0;
        do_reset();
        @(negedge clk);
        req1_valid = 1; req1_a = 32'hA; req1_b = 32'h5; req1_f = 3'b011;
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (resp1_valid !== 1'b1) $display("FAIL wd_resp1: got %b expected 1", resp1_valid);
        else n_pass++;
        req0_valid = 1; req0_a = 32'h3; req0_b = 32'h0; req0_f = 3'b000;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0) $display("FAIL wd_no_accept: got %b expected 0", req0_ready);
        else n_pass++;
        @(negedge clk);
        req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (resp0_valid) r0_seen = 1;
            @(negedge clk);
        end
        n_checks++;
        if (r0_seen !== 1'b0 || resp1_valid !== 1'b1 || resp_data !== 32'hF)
            $display("FAIL wd_quiet: resp0 seen=%b resp1_valid=%b data=%h expected 0/1/0000000f",
                     r0_seen, resp1_valid, resp_data);
        else n_pass++;
        resp1_ready = 1;
        @(negedge clk);
        resp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL wd_last_served: got %b expected 10", {req0_ready, req1_ready});
        else n_pass++;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_and();
        test_wrap();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_exec();
        test_withdrawal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
